// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the
// buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_div(
    input int clk_mhz,
    input int baud
  );
    return (clk_mhz * 1000000 + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with an extra
// pointer bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A push into a full FIFO is dropped even
  // when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 transmitter fed by a byte
// FIFO; back-to-back frames with no idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_MHZ    = 12,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    send_data,
  input  logic                          send_req,
  output logic                          ready,
  input  logic                          clear_overflow,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int DIV = calc_div(CLK_MHZ, BAUD);
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] CNT_TOP = CW'(DIV - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_fifo: DIV must be >= 2");
  end

  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_depth_chk
    $error("uart_tx_fifo: bad FIFO_DEPTH");
  end

  if (FRAME_BITS != DATA_BITS + 2) begin : g_frm_chk
    $error("uart_tx_fifo: frame is not 8N1");
  end

  tx_state_t      state;
  logic [CW-1:0]  cnt;
  logic [7:0]     shift;
  logic [2:0]     idx;

  logic           full;
  logic           empty;
  logic           pop;
  logic [7:0]     rd_data;

  assign ready = !full;
  assign busy  = (state != IDLE) || !empty;

  // Pop on leaving IDLE or at the end of a stop
  // bit, so the next frame starts without a gap.
  assign pop = !empty &&
               ((state == IDLE) ||
                (state == STOP && cnt == '0));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (send_req),
    .wr_data (send_data),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (send_req && !ready) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx    <= 1'b1;
      cnt   <= '0;
      shift <= '0;
      idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shift <= rd_data;
            tx    <= 1'b0;
            cnt   <= CNT_TOP;
            state <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            tx    <= shift[0];
            idx   <= '0;
            cnt   <= CNT_TOP;
            state <= DATA;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            cnt <= CNT_TOP;
            if (idx == LAST_BIT) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift <= shift >> 1;
              tx    <= shift[1];
              idx   <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (!empty) begin
              shift <= rd_data;
              tx    <= 1'b0;
              cnt   <= CNT_TOP;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench with a serial
// decoder and a byte scoreboard (DIV = 4).
module tb_uart_tx_fifo;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] send_data = '0;
  logic       send_req = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       ready;
  logic       tx;
  logic       busy;
  logic [4:0] level;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] exp_q [$];

  uart_tx_fifo #(
    .CLK_MHZ    (4),
    .BAUD       (1000000),
    .FIFO_DEPTH (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .send_data      (send_data),
    .send_req       (send_req),
    .ready          (ready),
    .clear_overflow (clear_overflow),
    .tx             (tx),
    .busy           (busy),
    .level          (level),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(
    input logic [7:0] b,
    input logic       acc
  );
    chk("ready_before_push", 32'(ready), 32'(acc));
    send_data = b;
    send_req  = 1'b1;
    if (acc) exp_q.push_back(b);
    @(posedge clk);
    #1;
    send_req = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Serial decoder: samples mid-bit on negedge.
  bit         rx_act = 1'b0;
  int         rx_off = 0;
  logic [7:0] rx_byte = '0;
  logic [7:0] rx_exp;

  always @(negedge clk) begin
    if (rst) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1'b1;
        rx_off = 0;
      end
    end else begin
      rx_off++;
      if (rx_off == DIV / 2) begin
        chk("start_bit", 32'(tx), 32'd0);
      end else if (rx_off > DIV &&
                   rx_off < 9 * DIV &&
                   rx_off % DIV == DIV / 2) begin
        rx_byte[3'(rx_off / DIV - 1)] = tx;
      end else if (rx_off == 9 * DIV + DIV / 2) begin
        chk("stop_bit", 32'(tx), 32'd1);
        chk("frame_expected",
            32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          rx_exp = exp_q.pop_front();
          chk("rx_byte", 32'(rx_byte), 32'(rx_exp));
        end
        rx_act = 1'b0;
      end
    end
  end

  logic [7:0] a5 = 8'hA5;
  logic       e_tx;
  int         n;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 100; i++) begin
      chk("idle_tx", 32'(tx), 32'd1);
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_level", 32'(level), 32'd0);
      @(posedge clk);
      #1;
    end

    // Single byte, cycle-exact waveform.
    push(8'hA5, 1'b1);
    chk("a5_tx_n", 32'(tx), 32'd1);
    chk("a5_level_n", 32'(level), 32'd1);
    chk("a5_busy_n", 32'(busy), 32'd1);
    for (int k = 1; k <= 41; k++) begin
      @(posedge clk);
      #1;
      if (k <= 4) e_tx = 1'b0;
      else if (k <= 36) e_tx = a5[(k - 5) / 4];
      else e_tx = 1'b1;
      chk("a5_tx", 32'(tx), 32'(e_tx));
      chk("a5_busy", 32'(busy), 32'(k < 41));
    end
    chk("a5_drained", 32'(exp_q.size()), 32'd0);

    // Fill: first byte leaves at once, 16 queue.
    push(8'h00, 1'b1);
    n = cyc;
    for (int i = 1; i <= 16; i++)
      push(8'(i), 1'b1);
    chk("full_ready", 32'(ready), 32'd0);
    chk("full_level", 32'(level), 32'd16);
    push(8'hFF, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    clear_overflow = 1'b1;
    @(posedge clk);
    #1;
    clear_overflow = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);
    clear_overflow = 1'b1;
    push(8'hFE, 1'b0);
    clear_overflow = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    @(posedge clk);
    #1;
    clear_overflow = 1'b0;
    chk("ovf_clear2", 32'(overflow), 32'd0);

    // Push on the pop edge while full: dropped.
    wait_until(n + 40);
    chk("pre_pop_level", 32'(level), 32'd16);
    push(8'hEE, 1'b0);
    chk("full_pp_level", 32'(level), 32'd15);
    chk("full_pp_ovf", 32'(overflow), 32'd1);
    chk("full_pp_ready", 32'(ready), 32'd1);
    clear_overflow = 1'b1;
    @(posedge clk);
    #1;
    clear_overflow = 1'b0;

    // Push on the pop edge while not full.
    wait_until(n + 80);
    chk("pp_level_before", 32'(level), 32'd15);
    push(8'hC3, 1'b1);
    chk("pp_level_after", 32'(level), 32'd15);

    // 18 frames must end exactly 720 clocks on.
    wait_until(n + 720);
    chk("burst_busy_end", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk("burst_busy_done", 32'(busy), 32'd0);
    chk("burst_tx_idle", 32'(tx), 32'd1);
    chk("burst_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a 3-byte burst.
    push(8'h11, 1'b1);
    n = cyc;
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    wait_until(n + 12);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("rst_quiet_tx", 32'(tx), 32'd1);
    end
    push(8'h3C, 1'b1);
    n = cyc;
    wait_until(n + 40);
    chk("3c_busy_end", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk("3c_busy_done", 32'(busy), 32'd0);
    chk("3c_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
